// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and helpers for the adder result accumulator
package adder_pkg;

  typedef enum logic {ACCUM, HOLD} acc_state_t;

  function automatic int cnt_width(input int count);
    return $clog2(count + 1);
  endfunction

endpackage

// File: rtl/adder_result_accumulator_if.sv
// rtl/adder_result_accumulator_if.sv - sample input and block output handshakes
interface adder_result_accumulator_if #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int COUNT     = 4
);
  import adder_pkg::*;

  localparam int CW = cnt_width(COUNT);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_result;
  logic                 in_carry;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic [CW-1:0]        out_count;
  logic                 out_overflow;

  modport master (
    output in_valid, in_result, in_carry, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_result, in_carry, flush, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_overflow
  );

endinterface

// File: rtl/adder.sv
// rtl/adder.sv - unsigned ripple adder with carry out
module adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  assign {carry_out, result} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_result_accumulator.sv
// rtl/adder_result_accumulator.sv - sums COUNT adder results per block, presents total with sticky overflow
module adder_result_accumulator
  import adder_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int COUNT     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  adder_result_accumulator_if.slave    bus
);

  localparam int CW = cnt_width(COUNT);

  acc_state_t           state, state_next;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] sample;
  logic [ACC_WIDTH-1:0] sum_next;
  logic                 add_carry;
  logic [CW-1:0]        cnt;
  logic                 ovf;
  logic                 accept;
  logic                 handoff;

  always_comb begin
    sample = '0;
    sample[WIDTH:0] = {bus.in_carry, bus.in_result};
  end

  adder #(.WIDTH(ACC_WIDTH)) u_acc_adder (
    .a         (acc),
    .b         (sample),
    .result    (sum_next),
    .carry_out (add_carry)
  );

  assign accept  = bus.in_valid && (state == ACCUM);
  assign handoff = (state == HOLD) && bus.out_ready;

  always_comb begin
    state_next = state;
    case (state)
      ACCUM: begin
        // a sample arriving with flush still belongs to the closing block
        if ((accept && cnt == CW'(COUNT - 1)) ||
            (bus.flush && (cnt != '0 || accept)))
          state_next = HOLD;
      end
      HOLD: begin
        if (bus.out_ready)
          state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        acc <= sum_next;
        cnt <= cnt + 1'b1;
        ovf <= ovf | add_carry;
      end else if (handoff) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = (state == ACCUM);
  assign bus.out_valid    = (state == HOLD);
  assign bus.out_sum      = (state == HOLD) ? acc : '0;
  assign bus.out_count    = (state == HOLD) ? cnt : '0;
  assign bus.out_overflow = (state == HOLD) ? ovf : 1'b0;

endmodule
